piso_serializer: RTL and testbench

//  Parallel-in serial-out transmitter. Accepts an N-bit word over a valid/ready load port
//  and shifts it out one bit per enabled cycle on sout. Provides framing flags so a

---
 rtl/piso_serializer.sv | 109 ++++++++++
 tb/tb_piso_serializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load port and frame flags.
// A new word can be accepted on the last-bit cycle so consecutive frames have no gap.
module piso_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_first,
  output logic         sout_last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  count_q, count_d;

  logic           accept;
  logic           consume;
  logic           at_last;
  logic           sout_bit;
  logic [N-1:0]   sreg_shifted;

  // Bit order is fixed at elaboration: pick the output tap and shift direction.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sout_bit     = sreg_q[N-1];
      assign sreg_shifted = {sreg_q[N-2:0], 1'b0};
    end else begin : g_lsb
      assign sout_bit     = sreg_q[0];
      assign sreg_shifted = {1'b0, sreg_q[N-1:1]};
    end
  endgenerate

  always_comb begin
    sout_valid = (state_q == SHIFT);
    at_last    = (count_q == LAST);
    sout_first = sout_valid && (count_q == '0);
    sout_last  = sout_valid && at_last;
    busy       = sout_valid;
    sout       = sout_valid && sout_bit;
    load_ready = (state_q == IDLE) || (sout_last && shift_en);
    accept     = load_valid && load_ready;
    consume    = sout_valid && shift_en;
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = din;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (consume) begin
          if (!at_last) begin
            sreg_d  = sreg_shifted;
            count_d = count_q + CW'(1);
          end else if (accept) begin
            // Reload on the last bit so the next frame starts without a bubble.
            sreg_d  = din;
            count_d = '0;
          end else begin
            state_d = IDLE;
            sreg_d  = '0;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance (N=8), checked
// against a word/bit-index model and an accepted-bits stream scoreboard.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din [2];
  logic       lv  [2];
  logic       se  [2];
  logic       lr  [2];
  logic       so  [2];
  logic       sv  [2];
  logic       sf  [2];
  logic       sl  [2];
  logic       bz  [2];

  int total = 0;
  int bad   = 0;

  // Reference model: current frame word plus bit position (-1 when idle).
  int         pos      [2];
  logic [7:0] word     [2];
  bit         acc_last [2];
  int         acc_pos  [2];
  int         vrun     [2];
  int         vmax     [2];
  bit exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];

  piso_serializer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .shift_en(se[0]), .sout(so[0]), .sout_valid(sv[0]), .sout_first(sf[0]),
    .sout_last(sl[0]), .busy(bz[0])
  );

  piso_serializer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .shift_en(se[1]), .sout(so[1]), .sout_valid(sv[1]), .sout_first(sf[1]),
    .sout_last(sl[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_word(input int i);
    word[i] = din[i];
    pos[i]  = 0;
    for (int k = 0; k < 8; k++) begin
      if (i == 0) exp_q0.push_back(din[i][7-k]);
      else        exp_q1.push_back(din[i][k]);
    end
  endtask

  // One clock: check outputs late in the cycle, then advance the model past the edge.
  task automatic cyc();
    logic e_sout, e_rdy, e_vld;
    bit   acc [2];
    bit   con [2];
    #3;
    for (int i = 0; i < 2; i++) begin
      e_vld  = (pos[i] >= 0);
      e_sout = !e_vld ? 1'b0 : ((i == 0) ? word[i][7-pos[i]] : word[i][pos[i]]);
      e_rdy  = !e_vld || ((pos[i] == 7) && se[i]);
      chk($sformatf("sout%0d", i),  16'(so[i]), 16'(e_sout));
      chk($sformatf("valid%0d", i), 16'(sv[i]), 16'(e_vld));
      chk($sformatf("first%0d", i), 16'(sf[i]), 16'(pos[i] == 0));
      chk($sformatf("last%0d", i),  16'(sl[i]), 16'(pos[i] == 7));
      chk($sformatf("busy%0d", i),  16'(bz[i]), 16'(e_vld));
      chk($sformatf("ready%0d", i), 16'(lr[i]), 16'(e_rdy));
      acc[i] = lv[i] && e_rdy;
      con[i] = e_vld && se[i];
      if (acc[i]) acc_pos[i] = pos[i];
      acc_last[i] = acc[i];
      if (sv[i] === 1'b1) vrun[i]++; else vrun[i] = 0;
      if (vrun[i] > vmax[i]) vmax[i] = vrun[i];
      if (con[i]) begin
        if (i == 0) begin
          chk("stream0_nonempty", 16'(exp_q0.size() > 0), 16'd1);
          if (exp_q0.size() > 0) chk("stream0", 16'(so[0]), 16'(exp_q0.pop_front()));
          got_q0.push_back(so[0]);
        end else begin
          chk("stream1_nonempty", 16'(exp_q1.size() > 0), 16'd1);
          if (exp_q1.size() > 0) chk("stream1", 16'(so[1]), 16'(exp_q1.pop_front()));
          got_q1.push_back(so[1]);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pos[i] < 0) begin
        if (acc[i]) start_word(i);
      end else if (se[i]) begin
        if (pos[i] < 7)   pos[i]++;
        else if (acc[i])  start_word(i);
        else              pos[i] = -1;
      end
    end
  endtask

  function automatic logic [15:0] pack_msb0();
    logic [15:0] b = '0;
    foreach (got_q0[k]) b = {b[14:0], got_q0[k]};
    return b;
  endfunction

  initial begin
    logic [7:0] b;
    int         n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; lv[i] = 1'b0; se[i] = 1'b0;
      pos[i] = -1; word[i] = '0; acc_last[i] = 1'b0; acc_pos[i] = -1;
      vrun[i] = 0; vmax[i] = 0;
    end
    #1 rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // Asynchronous reset in the middle of a word.
    din[0] = 8'hC3; lv[0] = 1'b1; cyc();
    lv[0] = 1'b0; se[0] = 1'b1;
    repeat (3) cyc();
    #2 rst = 1'b0;
    #1;
    chk("rst_sout",  16'(so[0]), 16'd0);
    chk("rst_valid", 16'(sv[0]), 16'd0);
    chk("rst_first", 16'(sf[0]), 16'd0);
    chk("rst_last",  16'(sl[0]), 16'd0);
    chk("rst_busy",  16'(bz[0]), 16'd0);
    chk("rst_ready", 16'(lr[0]), 16'd1);
    pos[0] = -1;
    exp_q0.delete(); got_q0.delete();
    cyc();
    rst = 1'b1;
    cyc();

    // MSB-first 8'hA5.
    din[0] = 8'hA5; lv[0] = 1'b1; cyc();
    lv[0] = 1'b0;
    repeat (9) cyc();
    chk("a5_count", 16'(got_q0.size()), 16'd8);
    chk("a5_bits", pack_msb0(), 16'h00A5);
    got_q0.delete();

    // LSB-first 8'h01.
    se[1] = 1'b1; din[1] = 8'h01; lv[1] = 1'b1; cyc();
    lv[1] = 1'b0;
    repeat (9) cyc();
    b = '0;
    for (int k = 0; k < 8 && k < got_q1.size(); k++) b[k] = got_q1[k];
    chk("lsb01_count", 16'(got_q1.size()), 16'd8);
    chk("lsb01_bits", 16'(b), 16'h0001);
    chk("lsb01_firstbit", 16'(got_q1.size() > 0 ? got_q1[0] : 1'b0), 16'd1);
    got_q1.delete();

    // Back-to-back: 8'hFF then 8'h00 held until accepted on the last-bit cycle.
    vmax[0] = 0; vrun[0] = 0;
    din[0] = 8'hFF; lv[0] = 1'b1; cyc();
    din[0] = 8'h00;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc_last[0] && n < 20);
    chk("b2b_accept_in_time", 16'(acc_last[0]), 16'd1);
    chk("b2b_accept_pos", 16'(acc_pos[0]), 16'd7);
    lv[0] = 1'b0;
    repeat (10) cyc();
    chk("b2b_run", 16'(vmax[0]), 16'd16);
    chk("b2b_count", 16'(got_q0.size()), 16'd16);
    chk("b2b_bits", pack_msb0(), 16'hFF00);
    got_q0.delete();

    // Stall for five cycles after three bits.
    din[0] = 8'h5A; lv[0] = 1'b1; cyc();
    lv[0] = 1'b0;
    repeat (3) cyc();
    se[0] = 1'b0;
    repeat (5) cyc();
    chk("stall_consumed", 16'(got_q0.size()), 16'd3);
    se[0] = 1'b1;
    repeat (6) cyc();
    chk("stall_count", 16'(got_q0.size()), 16'd8);
    chk("stall_bits", pack_msb0(), 16'h005A);
    got_q0.delete();

    // load_valid while busy and not on the last bit is ignored.
    din[0] = 8'h96; lv[0] = 1'b1; cyc();
    lv[0] = 1'b0;
    repeat (2) cyc();
    din[0] = 8'h3C; lv[0] = 1'b1; cyc();
    chk("notready_ignored", 16'(acc_last[0]), 16'd0);
    lv[0] = 1'b0; din[0] = 8'h00;
    repeat (8) cyc();
    chk("notready_count", 16'(got_q0.size()), 16'd8);
    chk("notready_bits", pack_msb0(), 16'h0096);
    got_q0.delete();

    // Random traffic on both instances; the source holds din/valid until accepted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(lv[i] && !acc_last[i])) begin
          lv[i]  = ($urandom_range(0, 2) != 0);
          din[i] = 8'($urandom);
        end
        se[i] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0; se[i] = 1'b1;
    end
    repeat (12) cyc();
    chk("drain0", 16'(exp_q0.size()), 16'd0);
    chk("drain1", 16'(exp_q1.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
